// File: rtl/card_dealer.sv
// Single-deck card source: deals without replacement using a free-running
// Galois LFSR for the start slot and a linear probe over the dealt-card mask.
module card_dealer #(
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int unsigned LOW_THRESHOLD = 10
) (
  input  logic       clk_200Hz,
  input  logic       rst_n,
  input  logic       deal_req,
  input  logic       shuffle_req,
  output logic       card_valid,
  output logic [3:0] card_index,
  output logic [3:0] card_value,
  output logic [5:0] cards_left,
  output logic       busy,
  output logic       deck_low
);

  localparam int unsigned NUM_CARDS = 52;
  localparam logic [5:0]  DECK_SIZE = 6'(NUM_CARDS);
  localparam logic [5:0]  LAST_SLOT = 6'(NUM_CARDS - 1);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic {
    IDLE  = 1'b0,
    PROBE = 1'b1
  } state_e;

  state_e                 state_q;
  logic [NUM_CARDS-1:0]   mask_q;
  logic [5:0]             cards_left_q;
  logic [5:0]             cand_q;
  logic [15:0]            lfsr_q;
  logic [15:0]            lfsr_d;
  logic [5:0]             start_d;
  logic                   card_valid_q;
  logic [3:0]             card_index_q;
  logic [3:0]             card_value_q;
  logic                   busy_q;

  // Blackjack value of a rank: ace counts 11, faces count 10.
  function automatic logic [3:0] rank_value(input logic [3:0] rank);
    if (rank == 4'd0) begin
      return 4'd11;
    end else if (rank >= 4'd9) begin
      return 4'd10;
    end else begin
      return 4'(rank + 4'd1);
    end
  endfunction

  always_comb begin
    lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    start_d = (lfsr_q[5:0] < DECK_SIZE) ? lfsr_q[5:0] : 6'(lfsr_q[5:0] - DECK_SIZE);
  end

  always_ff @(posedge clk_200Hz) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      cards_left_q <= DECK_SIZE;
      cand_q       <= 6'd0;
      lfsr_q       <= SEED_EFF;
      card_valid_q <= 1'b0;
      card_index_q <= 4'd0;
      card_value_q <= 4'd0;
      busy_q       <= 1'b0;
    end else begin
      lfsr_q       <= lfsr_d;
      card_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (deal_req) begin
            cand_q  <= start_d;
            busy_q  <= 1'b1;
            state_q <= PROBE;
            // An empty deck (or a simultaneous shuffle) is refilled before probing.
            if ((cards_left_q == 6'd0) || shuffle_req) begin
              mask_q       <= '0;
              cards_left_q <= DECK_SIZE;
            end
          end else if (shuffle_req) begin
            mask_q       <= '0;
            cards_left_q <= DECK_SIZE;
          end
        end
        PROBE: begin
          if (!mask_q[cand_q]) begin
            mask_q[cand_q] <= 1'b1;
            card_index_q   <= cand_q[5:2];
            card_value_q   <= rank_value(cand_q[5:2]);
            cards_left_q   <= 6'(cards_left_q - 6'd1);
            card_valid_q   <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end else begin
            cand_q <= (cand_q == LAST_SLOT) ? 6'd0 : 6'(cand_q + 6'd1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign card_valid = card_valid_q;
  assign card_index = card_index_q;
  assign card_value = card_value_q;
  assign cards_left = cards_left_q;
  assign busy       = busy_q;
  assign deck_low   = (32'(cards_left_q) < LOW_THRESHOLD);

endmodule
